// File: rtl/segre_hazard_unit.sv
// Hazard controller for the decode stage: tracks in-flight destinations in EX/MEM/WB,
// selects operand bypasses, raises load-use stalls and applies branch flushes.
package segre_hazard_pkg;
  typedef enum logic [1:0] {
    ID_RF            = 2'd0,
    EXECUTE_BYPASS   = 2'd1,
    MEMORY_BYPASS    = 2'd2,
    WRITEBACK_BYPASS = 2'd3
  } bypass_id_sel_e;
endpackage

module segre_hazard_unit
  import segre_hazard_pkg::*;
#(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_id_i,
  input  logic [REG_SIZE-1:0]  src_a_identifier_i,
  input  logic [REG_SIZE-1:0]  src_b_identifier_i,
  input  logic                 rd_raddr_a_i,
  input  logic                 rd_raddr_b_i,
  input  logic                 rf_we_id_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_id_i,
  input  logic                 prod_data_stage_ex_i,
  input  logic                 prod_data_stage_mem_i,
  input  logic                 branch_taken_i,
  output bypass_id_sel_e       mux_sel_a_id_o,
  output bypass_id_sel_e       mux_sel_b_id_o,
  output logic                 block_if_o,
  output logic                 block_id_o,
  output logic                 bubble_ex_o,
  output logic                 inject_nops_o,
  output logic [CNT_WIDTH-1:0] stall_count_o
);

  localparam int NUM_SLOTS = 3;  // 0 = EX, 1 = MEM, 2 = WB

  typedef struct packed {
    logic                v;
    logic                we;
    logic [REG_SIZE-1:0] waddr;
    logic                late;
  } slot_t;

  slot_t                slot_reg [NUM_SLOTS];
  slot_t                ex_next;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  logic [REG_SIZE-1:0]  src_id [2];
  logic                 rd_en  [2];
  logic                 stall_raw;

  assign src_id[0] = src_a_identifier_i;
  assign src_id[1] = src_b_identifier_i;
  assign rd_en[0]  = rd_raddr_a_i;
  assign rd_en[1]  = rd_raddr_b_i;

  // Per-operand resolution; the youngest matching producer wins.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic [NUM_SLOTS-1:0] hit;
      bypass_id_sel_e       sel;
      logic                 stall;

      for (genvar gj = 0; gj < NUM_SLOTS; gj++) begin : g_slot
        assign hit[gj] = rd_en[gi] && (src_id[gi] != '0) && slot_reg[gj].v &&
                         slot_reg[gj].we && (slot_reg[gj].waddr == src_id[gi]);
      end

      always_comb begin
        sel   = ID_RF;
        stall = 1'b0;
        if (hit[0]) begin
          if (slot_reg[0].late) stall = 1'b1;
          else                  sel   = EXECUTE_BYPASS;
        end else if (hit[1]) begin
          sel = MEMORY_BYPASS;
        end else if (hit[2]) begin
          sel = WRITEBACK_BYPASS;
        end
      end
    end
  endgenerate

  // A taken branch squashes the ID instruction, so it can never be the one stalled.
  assign stall_raw = valid_id_i && (g_operand[0].stall || g_operand[1].stall) && !branch_taken_i;

  always_comb begin
    ex_next = '0;
    if (valid_id_i && !stall_raw && !branch_taken_i) begin
      ex_next.v     = 1'b1;
      ex_next.we    = rf_we_id_i;
      ex_next.waddr = rf_waddr_id_i;
      ex_next.late  = prod_data_stage_mem_i && !prod_data_stage_ex_i;
    end
  end

  assign count_next = (stall_raw && (count_reg != '1)) ? count_reg + CNT_WIDTH'(1) : count_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_reg[i] <= '0;
      count_reg <= '0;
    end else begin
      slot_reg[2] <= slot_reg[1];
      slot_reg[1] <= slot_reg[0];
      slot_reg[0] <= ex_next;
      count_reg   <= count_next;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign mux_sel_a_id_o = rst_i ? ID_RF : g_operand[0].sel;
  assign mux_sel_b_id_o = rst_i ? ID_RF : g_operand[1].sel;
  assign block_if_o     = stall_raw && !rst_i;
  assign block_id_o     = stall_raw && !rst_i;
  assign bubble_ex_o    = (stall_raw || branch_taken_i) && !rst_i;
  assign inject_nops_o  = branch_taken_i && !rst_i;
  assign stall_count_o  = count_reg;

endmodule

// File: tb/tb_segre_hazard_unit.sv
// Bench for segre_hazard_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a history-based reference model.
module tb_segre_hazard_unit;
  import segre_hazard_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           valid_id_i;
  logic [4:0]     src_a_identifier_i, src_b_identifier_i;
  logic           rd_raddr_a_i, rd_raddr_b_i;
  logic           rf_we_id_i;
  logic [4:0]     rf_waddr_id_i;
  logic           prod_data_stage_ex_i, prod_data_stage_mem_i;
  logic           branch_taken_i;
  bypass_id_sel_e mux_sel_a_id_o, mux_sel_b_id_o;
  logic           block_if_o, block_id_o, bubble_ex_o, inject_nops_o;
  logic [31:0]    stall_count_o;

  segre_hazard_unit #(.REG_SIZE(5), .CNT_WIDTH(32)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .valid_id_i            (valid_id_i),
    .src_a_identifier_i    (src_a_identifier_i),
    .src_b_identifier_i    (src_b_identifier_i),
    .rd_raddr_a_i          (rd_raddr_a_i),
    .rd_raddr_b_i          (rd_raddr_b_i),
    .rf_we_id_i            (rf_we_id_i),
    .rf_waddr_id_i         (rf_waddr_id_i),
    .prod_data_stage_ex_i  (prod_data_stage_ex_i),
    .prod_data_stage_mem_i (prod_data_stage_mem_i),
    .branch_taken_i        (branch_taken_i),
    .mux_sel_a_id_o        (mux_sel_a_id_o),
    .mux_sel_b_id_o        (mux_sel_b_id_o),
    .block_if_o            (block_if_o),
    .block_id_o            (block_id_o),
    .bubble_ex_o           (bubble_ex_o),
    .inject_nops_o         (inject_nops_o),
    .stall_count_o         (stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: hist[k] is the instruction that entered EX k+1 cycles ago (age k+1).
  typedef struct {
    bit v;
    bit we;
    int rd;
    bit late;
  } rec_t;

  rec_t    hist [3];
  longint  m_count;
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bypass_id_sel_e age_sel(input int age);
    case (age)
      1:       return EXECUTE_BYPASS;
      2:       return MEMORY_BYPASS;
      3:       return WRITEBACK_BYPASS;
      default: return ID_RF;
    endcase
  endfunction

  // Youngest in-flight writer of id decides; a not-yet-ready load one cycle ahead stalls.
  function automatic void resolve(input bit en, input int id,
                                  output bypass_id_sel_e sel, output bit st);
    sel = ID_RF;
    st  = 1'b0;
    if (!en || id == 0) return;
    for (int age = 1; age <= 3; age++) begin
      if (hist[age-1].v && hist[age-1].we && hist[age-1].rd == id) begin
        if (age == 1 && hist[0].late) st = 1'b1;
        else                          sel = age_sel(age);
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    bypass_id_sel_e sa, sb;
    bit ta, tb;
    resolve(rd_raddr_a_i, int'(src_a_identifier_i), sa, ta);
    resolve(rd_raddr_b_i, int'(src_b_identifier_i), sb, tb);
    return valid_id_i && (ta || tb) && !branch_taken_i;
  endfunction

  task automatic compare_all();
    bypass_id_sel_e sa, sb;
    bit ta, tb, st;
    resolve(rd_raddr_a_i, int'(src_a_identifier_i), sa, ta);
    resolve(rd_raddr_b_i, int'(src_b_identifier_i), sb, tb);
    st = valid_id_i && (ta || tb) && !branch_taken_i;
    if (rst_i) begin
      chk("rst_sel_a", mux_sel_a_id_o, ID_RF);
      chk("rst_sel_b", mux_sel_b_id_o, ID_RF);
      chk("rst_block_if", block_if_o, 0);
      chk("rst_block_id", block_id_o, 0);
      chk("rst_bubble", bubble_ex_o, 0);
      chk("rst_inject", inject_nops_o, 0);
      chk("rst_count", stall_count_o, 0);
    end else begin
      chk("sel_a", mux_sel_a_id_o, sa);
      chk("sel_b", mux_sel_b_id_o, sb);
      chk("block_if", block_if_o, st);
      chk("block_id", block_id_o, st);
      chk("bubble_ex", bubble_ex_o, st || branch_taken_i);
      chk("inject_nops", inject_nops_o, branch_taken_i);
      chk("stall_count", stall_count_o, m_count);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
    m_count = 0;
  endtask

  task automatic drive(input bit v, input int a, input int b, input bit ra, input bit rb,
                       input bit we, input int rd, input bit pex, input bit pmem, input bit br);
    valid_id_i            = v;
    src_a_identifier_i    = 5'(a);
    src_b_identifier_i    = 5'(b);
    rd_raddr_a_i          = ra;
    rd_raddr_b_i          = rb;
    rf_we_id_i            = we;
    rf_waddr_id_i         = 5'(rd);
    prod_data_stage_ex_i  = pex;
    prod_data_stage_mem_i = pmem;
    branch_taken_i        = br;
    #2;
    compare_all();
  endtask

  task automatic tick();
    bit st;
    @(posedge clk_i);
    if (rst_i) begin
      clear_model();
    end else begin
      st = model_stall();
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (valid_id_i && !st && !branch_taken_i)
        hist[0] = '{1, rf_we_id_i, int'(rf_waddr_id_i),
                    prod_data_stage_mem_i && !prod_data_stage_ex_i};
      else
        hist[0] = '{0, 0, 0, 0};
      if (st && m_count != 64'hFFFF_FFFF) m_count++;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  bypass_id_sel_e sweep_exp [4];

  initial begin
    clear_model();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_i = 1'b0;

    // Forward from EX
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 0, 1, 1, 1, 2, 1, 0, 0);
    chk("lit_fwd_ex_a", mux_sel_a_id_o, EXECUTE_BYPASS);
    chk("lit_fwd_ex_b", mux_sel_b_id_o, ID_RF);
    chk("lit_fwd_ex_block_id", block_id_o, 0);
    tick();

    // Load-use
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    tick();
    drive(1, 5, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("lit_lu_block_if", block_if_o, 1);
    chk("lit_lu_block_id", block_id_o, 1);
    chk("lit_lu_bubble", bubble_ex_o, 1);
    chk("lit_lu_count_before", stall_count_o, 0);
    tick();
    drive(1, 5, 5, 1, 1, 1, 6, 1, 0, 0);
    chk("lit_lu_count_after", stall_count_o, 1);
    chk("lit_lu_sel_a", mux_sel_a_id_o, MEMORY_BYPASS);
    chk("lit_lu_sel_b", mux_sel_b_id_o, MEMORY_BYPASS);
    chk("lit_lu_no_stall", block_id_o, 0);
    tick();

    // Distance sweep
    sweep_exp[0] = EXECUTE_BYPASS;
    sweep_exp[1] = MEMORY_BYPASS;
    sweep_exp[2] = WRITEBACK_BYPASS;
    sweep_exp[3] = ID_RF;
    for (int k = 1; k <= 4; k++) begin
      idle(3);
      drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
      tick();
      idle(k - 1);
      drive(1, 3, 0, 1, 0, 1, 8, 1, 0, 0);
      chk($sformatf("lit_sweep_k%0d", k), mux_sel_a_id_o, sweep_exp[k-1]);
      tick();
    end

    // x0 producer and disabled read
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, 1, 1, 1, 7, 1, 0, 0);
    chk("lit_x0_block_id", block_id_o, 0);
    chk("lit_x0_sel_a", mux_sel_a_id_o, ID_RF);
    chk("lit_x0_sel_b", mux_sel_b_id_o, ID_RF);
    tick();
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    tick();
    drive(1, 0, 4, 0, 0, 1, 9, 1, 0, 0);
    chk("lit_noread_sel_b", mux_sel_b_id_o, ID_RF);
    tick();

    // Stall vs flush
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    tick();
    drive(1, 5, 5, 1, 1, 1, 6, 1, 0, 1);
    chk("lit_flush_inject", inject_nops_o, 1);
    chk("lit_flush_bubble", bubble_ex_o, 1);
    chk("lit_flush_block_id", block_id_o, 0);
    chk("lit_flush_block_if", block_if_o, 0);
    tick();
    drive(1, 6, 0, 1, 0, 1, 11, 1, 0, 0);
    chk("lit_flush_count", stall_count_o, 1);
    chk("lit_flush_squashed_sel_a", mux_sel_a_id_o, ID_RF);
    tick();

    // Reset mid-stall
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 9, 0, 1, 0);
    tick();
    drive(1, 9, 0, 1, 0, 1, 10, 1, 0, 0);
    chk("lit_rst_pre_block_id", block_id_o, 1);
    #1 rst_i = 1'b1;
    #1;
    compare_all();
    chk("lit_rst_block_id", block_id_o, 0);
    chk("lit_rst_bubble", bubble_ex_o, 0);
    chk("lit_rst_count", stall_count_o, 0);
    tick();
    rst_i = 1'b0;
    drive(1, 9, 0, 1, 0, 1, 10, 1, 0, 0);
    chk("lit_rst_after_sel_a", mux_sel_a_id_o, ID_RF);
    chk("lit_rst_after_block_id", block_id_o, 0);
    tick();

    // Randomized run with small register range to provoke frequent hazards
    for (int n = 0; n < 3000; n++) begin
      bit is_load;
      rst_i   = ($urandom_range(0, 199) == 0);
      is_load = ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 9) != 0,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            1'($urandom), 1'($urandom),
            $urandom_range(0, 4) != 0, int'($urandom_range(0, 4)),
            !is_load, is_load,
            $urandom_range(0, 9) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/segre_hazard_unit.md
Name: segre_hazard_unit

Overview:
- Controller-side counterpart of the decode stage's hazard interface.
- Consumes the decode stage's source identifiers, read-enables, destination info and produce-stage flags. Returns per-operand bypass selects plus stall and flush controls.
- Keeps a 3-slot shadow of in-flight destinations (EX, MEM, WB) so it can decide forwarding and load-use stalls.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_SIZE, 5, register address width.
- CNT_WIDTH, 32, stall counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- valid_id_i  in  1  ID holds a valid instruction
- src_a_identifier_i  in  REG_SIZE  rs1 of ID instruction
- src_b_identifier_i  in  REG_SIZE  rs2 of ID instruction
- rd_raddr_a_i  in  1  ID instruction reads rs1
- rd_raddr_b_i  in  1  ID instruction reads rs2
- rf_we_id_i  in  1  ID instruction writes rd
- rf_waddr_id_i  in  REG_SIZE  rd of ID instruction
- prod_data_stage_ex_i  in  1  result available at end of EX
- prod_data_stage_mem_i  in  1  result available only at end of MEM (loads)
- branch_taken_i  in  1  taken branch/jump resolved in EX this cycle
- mux_sel_a_id_o  out  bypass_id_sel_e  rs1 operand select
- mux_sel_b_id_o  out  bypass_id_sel_e  rs2 operand select
- block_if_o  out  1  hold IF (PC and fetch register)
- block_id_o  out  1  hold ID register
- bubble_ex_o  out  1  ID instruction must not enter EX (insert NOP)
- inject_nops_o  out  1  flush IF/ID registers
- stall_count_o  out  CNT_WIDTH  load-use stall cycles since reset

Behaviour:
- Shadow slots: each of EX, MEM and WB holds {v, we, waddr, late}. late = prod_data_stage_mem_i & ~prod_data_stage_ex_i at capture.
- Each cycle the slots shift: WB<=MEM, MEM<=EX.
- EX slot capture:
  - loads the ID info when valid_id_i & ~stall & ~branch_taken_i;
  - otherwise it becomes invalid (v=0).
- Downstream stages never stall; the shift is unconditional.
- Match for operand x means all of: rd_raddr_x_i=1, identifier != 0, slot.v & slot.we, and slot.waddr == identifier.
- Operand select priority is youngest first:
  - EX match & ~late -> EXECUTE_BYPASS;
  - EX match & late -> stall_x=1, select don't-care (drive ID_RF);
  - else MEM match -> MEMORY_BYPASS;
  - else WB match -> WRITEBACK_BYPASS;
  - else ID_RF.
- The RF is written at the end of WB, so a match only 4+ cycles later reads ID_RF.
- Stall condition: stall = valid_id_i & (stall_a | stall_b) & ~branch_taken_i.
- While stalled: block_if_o = block_id_o = bubble_ex_o = 1.
- A load-use stall always lasts exactly 1 cycle. Next cycle the load sits in MEM, and the select becomes MEMORY_BYPASS.
- Flush: inject_nops_o = branch_taken_i and bubble_ex_o = 1 in that cycle. Flush overrides stall: block_if_o = block_id_o = 0 and the counter does not increment.
- Selects, block, bubble and inject are combinational from the slots and current inputs. The slots and counter are registered.
- stall_count_o increments by 1 on each cycle where stall=1 and saturates at all-ones.
- Reset (async, any time including mid-stall):
  - all slots v=0 and stall_count_o=0;
  - while rst_i=1, all 1-bit outputs are 0 and both selects are ID_RF;
  - the first cycle after release is treated as an empty pipeline.
- rd = x0 never produces a match. valid_id_i=0 never stalls.
- If a and b both hit the same late EX producer, the result is a single 1-cycle stall.
- Operands a and b are resolved independently; for example a=EXECUTE_BYPASS and b=WRITEBACK_BYPASS in the same cycle is legal.

Test Plan:
- Forward from EX: addi x1 (prod_ex=1) at cycle t, then add x2,x1,x0 at t+1 -> at t+1 mux_sel_a=EXECUTE_BYPASS, mux_sel_b=ID_RF, block_id_o=0.
- Load-use: lw x5 (prod_mem=1, prod_ex=0) at t, then add x6,x5,x5 at t+1:
  - t+1: block_if=block_id=bubble_ex=1, stall_count 0->1;
  - t+2: both selects=MEMORY_BYPASS, no stall.
- Distance sweep, producer x3 at t with a reader of x3 at t+k:
  - k=1 -> EXECUTE_BYPASS;
  - k=2 -> MEMORY_BYPASS;
  - k=3 -> WRITEBACK_BYPASS;
  - k=4 -> ID_RF.
- x0 and disabled read:
  - lw x0 followed by add x7,x0,x0 -> no stall, selects ID_RF;
  - a reader with rd_raddr_b_i=0 and a matching rs2 -> mux_sel_b=ID_RF.
- Stall vs flush: load-use pair with branch_taken_i=1 in the same cycle:
  - inject_nops=1, bubble_ex=1, block_id=0, stall_count unchanged;
  - next cycle the EX slot is invalid, so no forward from the squashed instruction.
- Reset mid-stall: assert rst_i while block_id_o=1 -> all outputs immediately 0/ID_RF, stall_count_o=0; after release a reader of the old load's rd gets ID_RF.
